// File: rtl/spatial_accumulator_weighted.sv
// rtl/spatial_accumulator_weighted.sv - weighted per-bit majority bundling of channel hypervectors
module spatial_accumulator_weighted #(
  parameter int HV_DIMENSION  = 2000,
  parameter int NUM_CHANNELS  = 4,
  parameter int FEATURE_WIDTH = 2
) (
  input  logic                      Clk_CI,
  input  logic                      Reset_RBI,
  input  logic                      ValidIn_SI,
  output logic                      ReadyOut_SO,
  input  logic                      LastIn_SI,
  input  logic [0:HV_DIMENSION-1]   HypervectorIn_DI,
  input  logic [FEATURE_WIDTH-1:0]  FeatureIn_DI,
  output logic                      ValidOut_SO,
  input  logic                      ReadyIn_SI,
  output logic [0:HV_DIMENSION-1]   HypervectorOut_DO,
  output logic                      Overflow_SO
);

  // Worst-case weighted sum of one bit position across a full frame.
  localparam int MAX_SUM   = NUM_CHANNELS * ((1 << FEATURE_WIDTH) - 1);
  // Extra top bit lets 2*count be formed without leaving the counter width.
  localparam int CNT_WIDTH = $clog2(MAX_SUM + 1) + 1;
  localparam int CH_WIDTH  = $clog2(NUM_CHANNELS + 1);

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_THRESH = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [CNT_WIDTH-1:0]    r_cnt [HV_DIMENSION];
  logic [CNT_WIDTH-1:0]    r_total;
  logic [0:HV_DIMENSION-1] r_tie_hv;
  logic [0:HV_DIMENSION-1] r_hv_out;
  logic                    r_first;
  logic [CH_WIDTH-1:0]     r_chan;
  logic                    r_overflow;

  logic                    w_accept;
  logic                    w_emit;
  logic [CH_WIDTH-1:0]     w_chan_inc;
  logic                    w_final_chan;
  logic                    w_close;
  logic                    w_overflow_set;
  logic [CNT_WIDTH-1:0]    w_weight;
  logic [0:HV_DIMENSION-1] w_thresh;

  assign w_accept       = ValidIn_SI & ReadyOut_SO;
  assign w_emit         = ValidOut_SO & ReadyIn_SI;
  assign w_chan_inc     = r_first ? CH_WIDTH'(1) : (r_chan + CH_WIDTH'(1));
  assign w_final_chan   = (w_chan_inc == CH_WIDTH'(NUM_CHANNELS));
  assign w_close        = w_accept & (LastIn_SI | w_final_chan);
  assign w_overflow_set = w_accept & w_final_chan & ~LastIn_SI;
  assign w_weight       = CNT_WIDTH'(FeatureIn_DI);

  // State register.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: a closing accept leaves ACCUM, THRESH lasts one cycle, OUT waits for emit.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCUM:  if (w_close) w_state_next = ST_THRESH;
      ST_THRESH: w_state_next = ST_OUT;
      ST_OUT:    if (w_emit) w_state_next = ST_ACCUM;
      default:   w_state_next = ST_ACCUM;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    ReadyOut_SO = 1'b0;
    ValidOut_SO = 1'b0;
    case (r_state)
      ST_ACCUM: ReadyOut_SO = 1'b1;
      ST_OUT:   ValidOut_SO = 1'b1;
      default: begin
        ReadyOut_SO = 1'b0;
        ValidOut_SO = 1'b0;
      end
    endcase
  end

  // Frame bookkeeping: first-of-frame flag and channel count.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      r_first <= 1'b1;
      r_chan  <= '0;
    end else if (w_accept) begin
      r_first <= w_close;
      r_chan  <= w_chan_inc;
    end
  end

  // Per-bit weighted counters; the first accept loads rather than adds, so no clear cycle.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      for (int i = 0; i < HV_DIMENSION; i++) begin
        r_cnt[i] <= '0;
      end
      r_total  <= '0;
      r_tie_hv <= '0;
    end else if (w_accept) begin
      if (r_first) begin
        for (int i = 0; i < HV_DIMENSION; i++) begin
          r_cnt[i] <= HypervectorIn_DI[i] ? w_weight : '0;
        end
        r_total  <= w_weight;
        r_tie_hv <= HypervectorIn_DI;
      end else begin
        for (int i = 0; i < HV_DIMENSION; i++) begin
          r_cnt[i] <= r_cnt[i] + (HypervectorIn_DI[i] ? w_weight : '0);
        end
        r_total <= r_total + w_weight;
      end
    end
  end

  // Majority decision per bit: compare 2*count against the frame total, ties take TieHV.
  always_comb begin
    w_thresh = '0;
    for (int i = 0; i < HV_DIMENSION; i++) begin
      if ({r_cnt[i][CNT_WIDTH-2:0], 1'b0} > r_total) begin
        w_thresh[i] = 1'b1;
      end else if ({r_cnt[i][CNT_WIDTH-2:0], 1'b0} < r_total) begin
        w_thresh[i] = 1'b0;
      end else begin
        w_thresh[i] = r_tie_hv[i];
      end
    end
  end

  // Output register captures the decision only while in THRESH, then holds.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      r_hv_out <= '0;
    end else if (r_state == ST_THRESH) begin
      r_hv_out <= w_thresh;
    end
  end

  // Overflow flag is high exactly during the THRESH cycle of a forcibly closed frame.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_overflow_set;
    end
  end

  assign HypervectorOut_DO = r_hv_out;
  assign Overflow_SO       = r_overflow;

endmodule
